// File: rtl/bfp_frame_scaler.sv
// bfp_frame_scaler: buffers one complex frame, finds its peak MSB index and replays it block-scaled
module bfp_frame_scaler #(
   parameter int WIDTH     = 23,
   parameter int OUT_WIDTH = 16,
   parameter int FRAME_LEN = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [WIDTH-1:0]           din_re,
   input  logic [WIDTH-1:0]           din_im,
   input  logic                       din_valid,
   output logic                       din_ready,
   output logic [OUT_WIDTH-1:0]       dout_re,
   output logic [OUT_WIDTH-1:0]       dout_im,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       dout_last,
   output logic [$clog2(WIDTH)-1:0]   blk_exp
);
   localparam int AW = $clog2(FRAME_LEN);
   localparam int EW = $clog2(WIDTH);
   localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);
   localparam logic [EW:0]   OW   = (EW + 1)'(OUT_WIDTH);

   typedef enum logic [1:0] {FILL, SCALE, DRAIN} state_t;

   state_t                 r_state, w_next;
   logic [2*WIDTH-1:0]     r_mem [FRAME_LEN];
   logic [AW-1:0]          r_wr_ptr, r_rd_ptr, w_rd_addr;
   logic [EW-1:0]          r_max, w_max_nxt, w_idx_re, w_idx_im, w_shift, w_sh;
   logic [EW:0]            w_sum;
   logic [OUT_WIDTH-1:0]   r_dout_re, r_dout_im, w_sc_re, w_sc_im;
   logic                   r_dout_valid, r_dout_last;
   logic [EW-1:0]          r_blk_exp;
   logic [2*WIDTH-1:0]     w_rd;
   logic                   w_in_xfer, w_out_xfer;

   // highest bit below the sign bit that differs from it; 0 for 0 and -1
   function automatic logic [EW-1:0] f_idx(input logic [WIDTH-1:0] x);
      f_idx = '0;
      for (int i = 0; i < WIDTH - 1; i++)
         if (x[i] != x[WIDTH-1]) f_idx = EW'(i);
   endfunction

   assign din_ready  = (r_state == FILL) && !rst;
   assign w_in_xfer  = din_valid && din_ready;
   assign w_out_xfer = r_dout_valid && dout_ready;
   assign dout_re    = r_dout_re;
   assign dout_im    = r_dout_im;
   assign dout_valid = r_dout_valid;
   assign dout_last  = r_dout_last;
   assign blk_exp    = r_blk_exp;

   // running peak index, shift amount and the scaled read-side sample
   always_comb begin
      w_idx_re  = f_idx(din_re);
      w_idx_im  = f_idx(din_im);
      w_max_nxt = r_max;
      w_max_nxt = (w_idx_re > w_max_nxt) ? w_idx_re : w_max_nxt;
      w_max_nxt = (w_idx_im > w_max_nxt) ? w_idx_im : w_max_nxt;
      w_sum     = {1'b0, r_max} + (EW + 1)'(2);
      w_shift   = (w_sum > OW) ? EW'(w_sum - OW) : '0;
      w_sh      = (r_state == SCALE) ? w_shift : r_blk_exp;
      w_rd_addr = (r_state == SCALE) ? '0 : r_rd_ptr + 1'b1;
      w_rd      = r_mem[w_rd_addr];
      w_sc_re   = OUT_WIDTH'($signed(w_rd[WIDTH-1:0]) >>> w_sh);
      w_sc_im   = OUT_WIDTH'($signed(w_rd[2*WIDTH-1:WIDTH]) >>> w_sh);
   end

   // next-state: fill until the buffer is full, one scale cycle, drain until the last transfer
   always_comb begin
      w_next = r_state;
      w_next = (r_state == FILL  && w_in_xfer  && r_wr_ptr == LAST) ? SCALE :
               (r_state == SCALE)                                   ? DRAIN :
               (r_state == DRAIN && w_out_xfer && r_rd_ptr == LAST) ? FILL  : r_state;
   end

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= FILL;
      else     r_state <= w_next;
   end

   // frame buffer, written only while filling
   always_ff @(posedge clk) begin
      if (w_in_xfer) r_mem[r_wr_ptr] <= {din_im, din_re};
   end

   // pointers, peak tracking and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_max        <= '0;
         r_dout_re    <= '0;
         r_dout_im    <= '0;
         r_dout_valid <= 1'b0;
         r_dout_last  <= 1'b0;
         r_blk_exp    <= '0;
      end else begin
         if (w_in_xfer) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_max    <= w_max_nxt;
         end
         if (r_state == SCALE) begin
            r_blk_exp    <= w_shift;
            r_dout_re    <= w_sc_re;
            r_dout_im    <= w_sc_im;
            r_dout_valid <= 1'b1;
            r_dout_last  <= 1'b0;
         end else if (r_state == DRAIN && w_out_xfer) begin
            if (r_rd_ptr == LAST) begin
               r_dout_valid <= 1'b0;
               r_dout_last  <= 1'b0;
               r_rd_ptr     <= '0;
               r_max        <= '0;
            end else begin
               r_rd_ptr    <= r_rd_ptr + 1'b1;
               r_dout_re   <= w_sc_re;
               r_dout_im   <= w_sc_im;
               r_dout_last <= (w_rd_addr == LAST);
            end
         end
      end
   end
endmodule

// File: tb/tb_bfp_frame_scaler.sv
// tb_bfp_frame_scaler: random and directed frames checked by a scoreboard against an arithmetic model
module tb_bfp_frame_scaler;
   localparam int W  = 23;
   localparam int OW = 16;
   localparam int FL = 4;
   localparam int EW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  din_re = '0, din_im = '0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [OW-1:0] dout_re, dout_im;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic          dout_last;
   logic [EW-1:0] blk_exp;

   int checks = 0;
   int errors = 0;
   int q_re[$], q_im[$], q_exp[$];
   bit q_last[$];
   int f_re[FL], f_im[FL];
   bit bp = 1'b0;
   bit gap_en = 1'b0;

   bfp_frame_scaler #(.WIDTH(W), .OUT_WIDTH(OW), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst),
      .din_re(din_re), .din_im(din_im), .din_valid(din_valid), .din_ready(din_ready),
      .dout_re(dout_re), .dout_im(dout_im), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_last(dout_last), .blk_exp(blk_exp)
   );

   always #5 clk = ~clk;

   // position of the top magnitude bit, treating negatives by their one's complement
   function automatic int idx_of(longint v);
      longint m = (v < 0) ? -v - 1 : v;
      int n = 0;
      while (m > 1) begin
         m = m >> 1;
         n++;
      end
      return n;
   endfunction

   function automatic int rnd_val(int nb);
      int r;
      r = int'($urandom_range(0, (1 << nb) - 1));
      return r - (1 << (nb - 1));
   endfunction

   task automatic push_expect();
      int m = 0;
      int s;
      for (int k = 0; k < FL; k++) begin
         if (idx_of(f_re[k]) > m) m = idx_of(f_re[k]);
         if (idx_of(f_im[k]) > m) m = idx_of(f_im[k]);
      end
      s = m + 2 - OW;
      if (s < 0) s = 0;
      for (int k = 0; k < FL; k++) begin
         q_re.push_back(f_re[k] >>> s);
         q_im.push_back(f_im[k] >>> s);
         q_last.push_back(k == FL - 1);
         q_exp.push_back(s);
      end
   endtask

   task automatic send(int n, bit expect_out);
      int i = 0;
      int guard = 0;
      if (expect_out) push_expect();
      while (i < n && guard < 1000) begin
         @(posedge clk); #1;
         guard++;
         if (gap_en && $urandom_range(0, 3) == 0) din_valid = 1'b0;
         else begin
            din_valid = 1'b1;
            din_re = W'(f_re[i]);
            din_im = W'(f_im[i]);
            if (din_ready) i++;
         end
      end
      if (guard >= 1000) begin
         checks++; errors++;
         $display("FAIL send_timeout accepted %0d want %0d", i, n);
      end
      @(posedge clk); #1;
      din_valid = 1'b0;
      if (n == FL && expect_out && guard < 1000) begin
         checks++;
         if (dout_valid || din_ready) begin
            errors++;
            $display("FAIL scale_cycle dout_valid %0d din_ready %0d want 0 0", dout_valid, din_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (!dout_valid) begin
            errors++;
            $display("FAIL latency dout_valid %0d want 1", dout_valid);
         end
      end
   endtask

   task automatic rand_frame();
      int nb = $urandom_range(1, W);
      for (int k = 0; k < FL; k++) begin
         f_re[k] = rnd_val($urandom_range(1, nb));
         f_im[k] = rnd_val($urandom_range(1, nb));
      end
   endtask

   task automatic small_frame();
      for (int k = 0; k < FL; k++) begin
         f_re[k] = $urandom_range(0, 200) - 100;
         f_im[k] = $urandom_range(0, 200) - 100;
      end
   endtask

   task automatic wait_empty();
      int g = 0;
      while (q_re.size() != 0 && g < 2000) begin
         @(posedge clk);
         g++;
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      dout_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
   end

   bit stall = 1'b0, after_last = 1'b0;
   logic [OW-1:0] p_re, p_im;
   logic p_last;
   logic [EW-1:0] p_exp;

   always @(negedge clk) begin
      if (rst) begin
         stall = 1'b0;
         after_last = 1'b0;
      end else begin
         if (after_last) begin
            checks++;
            if (!din_ready) begin
               errors++;
               $display("FAIL ready_after_drain din_ready %0d want 1", din_ready);
            end
            after_last = 1'b0;
         end
         if (stall) begin
            checks++;
            if (!dout_valid || dout_re != p_re || dout_im != p_im || dout_last != p_last || blk_exp != p_exp) begin
               errors++;
               $display("FAIL hold valid %0d re %0d im %0d last %0d exp %0d want 1 %0d %0d %0d %0d",
                        dout_valid, dout_re, dout_im, dout_last, blk_exp, p_re, p_im, p_last, p_exp);
            end
         end
         if (dout_valid) begin
            checks++;
            if (din_ready) begin
               errors++;
               $display("FAIL ready_in_drain din_ready %0d want 0", din_ready);
            end
         end
         if (dout_valid && dout_ready) begin
            checks++;
            if (q_re.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output re %0d im %0d want none", $signed(dout_re), $signed(dout_im));
            end else begin
               int e_re, e_im, e_exp;
               bit e_last;
               e_re = q_re.pop_front();
               e_im = q_im.pop_front();
               e_last = q_last.pop_front();
               e_exp = q_exp.pop_front();
               if (int'($signed(dout_re)) != e_re || int'($signed(dout_im)) != e_im) begin
                  errors++;
                  $display("FAIL sample re %0d im %0d want %0d %0d", $signed(dout_re), $signed(dout_im), e_re, e_im);
               end
               checks++;
               if (dout_last != e_last) begin
                  errors++;
                  $display("FAIL last got %0d want %0d", dout_last, e_last);
               end
               checks++;
               if (int'(blk_exp) != e_exp) begin
                  errors++;
                  $display("FAIL blk_exp got %0d want %0d", blk_exp, e_exp);
               end
            end
            if (dout_last) after_last = 1'b1;
         end
         stall = dout_valid && !dout_ready;
         p_re = dout_re;
         p_im = dout_im;
         p_last = dout_last;
         p_exp = blk_exp;
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (dout_valid || dout_last || din_ready || blk_exp != 0 || dout_re != 0 || dout_im != 0) begin
         errors++;
         $display("FAIL reset_state valid %0d last %0d ready %0d exp %0d re %0d im %0d want all 0",
                  dout_valid, dout_last, din_ready, blk_exp, dout_re, dout_im);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (!din_ready) begin
         errors++;
         $display("FAIL ready_after_reset got %0d want 1", din_ready);
      end
      f_re = '{4194303, 0, -1, 100};
      f_im = '{0, 0, 0, 0};
      send(FL, 1'b1);
      small_frame();
      send(FL, 1'b1);
      f_re = '{0, 0, -32768, 0};
      send(FL, 1'b1);
      f_re = '{0, 0, 32768, 0};
      send(FL, 1'b1);
      bp = 1'b1;
      gap_en = 1'b1;
      for (int n = 0; n < 8; n++) begin
         rand_frame();
         send(FL, 1'b1);
      end
      wait_empty();
      bp = 1'b0;
      gap_en = 1'b0;
      f_re = '{4194303, -4194304, 0, 0};
      f_im = '{4194303, 0, 0, 0};
      send(2, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (din_ready) begin
         errors++;
         $display("FAIL ready_in_reset got %0d want 0", din_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      small_frame();
      send(FL, 1'b1);
      bp = 1'b1;
      gap_en = 1'b1;
      for (int n = 0; n < 6; n++) begin
         rand_frame();
         send(FL, 1'b1);
      end
      wait_empty();
      repeat (2) @(posedge clk);
      checks++;
      if (q_re.size() != 0) begin
         errors++;
         $display("FAIL drain_incomplete left %0d want 0", q_re.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
